// File: rtl/regfile_pkg.sv
// Shared sizing definitions for the register file, ROB and reservation stations.
package regfile_pkg;
  localparam int ROB_WIDTH = 4;
  localparam int ROB_SIZE  = 1 << ROB_WIDTH;
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
endpackage

// File: rtl/regfile_read_port.sv
// Combinational operand resolve for one source port: x0, committed value,
// same-cycle commit bypass, ROB search result, or a pending tag.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int ROB_WIDTH = regfile_pkg::ROB_WIDTH
) (
  input  logic [REG_IDX_W-1:0] i_src,
  input  logic                 i_busy,
  input  logic [ROB_WIDTH-1:0] i_dep,
  input  logic [XLEN-1:0]      i_reg_val,
  input  logic                 i_commit_valid,
  input  logic [ROB_WIDTH-1:0] i_commit_rob_id,
  input  logic [XLEN-1:0]      i_commit_val,
  input  logic                 i_search_ready,
  input  logic [XLEN-1:0]      i_search_val,
  output logic [XLEN-1:0]      o_val,
  output logic                 o_has_dep,
  output logic [ROB_WIDTH-1:0] o_dep
);

  logic w_bypass;

  assign w_bypass = i_commit_valid && (i_commit_rob_id == i_dep);

  always_comb begin
    o_val     = '0;
    o_has_dep = 1'b0;
    if (i_src == '0) begin
      o_val = '0;
    end else if (!i_busy) begin
      o_val = i_reg_val;
    end else if (w_bypass) begin
      o_val = i_commit_val;
    end else if (i_search_ready) begin
      o_val = i_search_val;
    end else begin
      o_has_dep = 1'b1;
    end
  end

  assign o_dep = i_dep;

endmodule

// File: rtl/regfile.sv
// Architectural register file with rename tags: resolves issue operands,
// records destination tags, absorbs ROB commits and drops renames on flush.
module regfile
  import regfile_pkg::*;
#(
  parameter int ROB_WIDTH = regfile_pkg::ROB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_ready,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [4:0]           dec_rd,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  output logic [31:0]          val1,
  output logic [31:0]          val2,
  output logic                 has_dep1,
  output logic                 has_dep2,
  output logic [ROB_WIDTH-1:0] dep1,
  output logic [ROB_WIDTH-1:0] dep2,
  output logic [ROB_WIDTH-1:0] search_rob_id_1,
  output logic [ROB_WIDTH-1:0] search_rob_id_2,
  input  logic                 search_ready_1,
  input  logic                 search_ready_2,
  input  logic [31:0]          search_val_1,
  input  logic [31:0]          search_val_2,
  input  logic                 commit_valid,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [4:0]           commit_reg_id,
  input  logic [31:0]          commit_val
);

  logic [XLEN-1:0]      r_regs [REG_NUM];
  logic [REG_NUM-1:0]   r_busy;
  logic [ROB_WIDTH-1:0] r_dep  [REG_NUM];

  logic w_commit_wr;
  logic w_issue_wr;

  assign w_commit_wr = commit_valid && (commit_reg_id != '0);
  assign w_issue_wr  = dec_ready && !clear && (dec_rd != '0);

  // Operands see pre-issue state, so an instruction never waits on its own rd.
  assign search_rob_id_1 = r_dep[dec_rs1];
  assign search_rob_id_2 = r_dep[dec_rs2];

  regfile_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rp1 (
    .i_src           (dec_rs1),
    .i_busy          (r_busy[dec_rs1]),
    .i_dep           (r_dep[dec_rs1]),
    .i_reg_val       (r_regs[dec_rs1]),
    .i_commit_valid  (commit_valid),
    .i_commit_rob_id (commit_rob_id),
    .i_commit_val    (commit_val),
    .i_search_ready  (search_ready_1),
    .i_search_val    (search_val_1),
    .o_val           (val1),
    .o_has_dep       (has_dep1),
    .o_dep           (dep1)
  );

  regfile_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rp2 (
    .i_src           (dec_rs2),
    .i_busy          (r_busy[dec_rs2]),
    .i_dep           (r_dep[dec_rs2]),
    .i_reg_val       (r_regs[dec_rs2]),
    .i_commit_valid  (commit_valid),
    .i_commit_rob_id (commit_rob_id),
    .i_commit_val    (commit_val),
    .i_search_ready  (search_ready_2),
    .i_search_val    (search_val_2),
    .o_val           (val2),
    .o_has_dep       (has_dep2),
    .o_dep           (dep2)
  );

  // Statement order sets priority: commit busy-release, then flush, then issue.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
        r_dep[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (w_commit_wr) begin
        r_regs[commit_reg_id] <= commit_val;
        if (r_busy[commit_reg_id] && (r_dep[commit_reg_id] == commit_rob_id)) begin
          r_busy[commit_reg_id] <= 1'b0;
        end
      end
      if (clear) begin
        r_busy <= '0;
      end else if (w_issue_wr) begin
        r_busy[dec_rd] <= 1'b1;
        r_dep[dec_rd]  <= dec_rob_id;
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Randomized and directed bench for regfile against an array-based reference model.
module tb_regfile;
  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clear;
  logic          dec_ready;
  logic [4:0]    dec_rs1, dec_rs2, dec_rd;
  logic [RW-1:0] dec_rob_id;
  logic [31:0]   val1, val2;
  logic          has_dep1, has_dep2;
  logic [RW-1:0] dep1, dep2;
  logic [RW-1:0] search_rob_id_1, search_rob_id_2;
  logic          search_ready_1, search_ready_2;
  logic [31:0]   search_val_1, search_val_2;
  logic          commit_valid;
  logic [RW-1:0] commit_rob_id;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_val;

  regfile #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dec_ready(dec_ready), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
    .val1(val1), .val2(val2), .has_dep1(has_dep1), .has_dep2(has_dep2),
    .dep1(dep1), .dep2(dep2),
    .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
    .search_ready_1(search_ready_1), .search_ready_2(search_ready_2),
    .search_val_1(search_val_1), .search_val_2(search_val_2),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0]   m_regs [32];
  logic          m_busy [32];
  logic [RW-1:0] m_dep  [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
      m_dep[i]  = '0;
    end
  endtask

  task automatic resolve(input logic [4:0] s, input logic sr, input logic [31:0] sv,
                         output logic [31:0] v, output logic hd);
    v  = '0;
    hd = 1'b0;
    if (s == 0)                                        v = '0;
    else if (!m_busy[s])                               v = m_regs[s];
    else if (commit_valid && commit_rob_id == m_dep[s]) v = commit_val;
    else if (sr)                                       v = sv;
    else                                               hd = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] ev1, ev2;
    logic        eh1, eh2;
    resolve(dec_rs1, search_ready_1, search_val_1, ev1, eh1);
    resolve(dec_rs2, search_ready_2, search_val_2, ev2, eh2);
    chk({tag, ".val1"}, val1, ev1);
    chk({tag, ".hd1"}, {31'b0, has_dep1}, {31'b0, eh1});
    chk({tag, ".val2"}, val2, ev2);
    chk({tag, ".hd2"}, {31'b0, has_dep2}, {31'b0, eh2});
    chk({tag, ".sid1"}, {28'b0, search_rob_id_1}, {28'b0, m_dep[dec_rs1]});
    chk({tag, ".sid2"}, {28'b0, search_rob_id_2}, {28'b0, m_dep[dec_rs2]});
    if (eh1) chk({tag, ".dep1"}, {28'b0, dep1}, {28'b0, m_dep[dec_rs1]});
    if (eh2) chk({tag, ".dep2"}, {28'b0, dep2}, {28'b0, m_dep[dec_rs2]});
  endtask

  task automatic model_update();
    if (rdy_in) begin
      if (commit_valid && commit_reg_id != 0) begin
        m_regs[commit_reg_id] = commit_val;
        if (m_busy[commit_reg_id] && m_dep[commit_reg_id] == commit_rob_id)
          m_busy[commit_reg_id] = 1'b0;
      end
      if (clear) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (dec_ready && dec_rd != 0) begin
        m_busy[dec_rd] = 1'b1;
        m_dep[dec_rd]  = dec_rob_id;
      end
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear = 1'b0; dec_ready = 1'b0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_rob_id = '0;
    search_ready_1 = 1'b0; search_ready_2 = 1'b0;
    search_val_1 = '0; search_val_2 = '0;
    commit_valid = 1'b0; commit_rob_id = '0; commit_reg_id = '0; commit_val = '0;
  endtask

  // Inputs are set just after a falling edge; outputs checked 1ns later, model advanced at the rising edge.
  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk_in);
    model_update();
    @(negedge clk_in);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [RW-1:0] rob);
    idle();
    dec_ready = 1'b1; dec_rd = rd; dec_rob_id = rob;
    step("issue");
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    model_reset();
    @(negedge clk_in);
    dec_rs1 = 5'd7; dec_rs2 = 5'd31;
    #1;
    chk("rst.val1", val1, 32'h0);
    chk("rst.hd1", {31'b0, has_dep1}, 32'h0);
    chk("rst.dep1", {28'b0, dep1}, 32'h0);
    chk("rst.sid2", {28'b0, search_rob_id_2}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Reads of x3 and x0 after reset
    idle(); dec_ready = 1'b1; dec_rs1 = 5'd3; dec_rs2 = 5'd0;
    #1;
    chk("t1.val1", val1, 32'h0);
    chk("t1.hd2", {31'b0, has_dep2}, 32'h0);
    step("t1");

    // Rename x5 -> rob 2, then search path
    issue(5'd5, 4'd2);
    idle(); dec_rs1 = 5'd5;
    #1;
    chk("t2.hd1", {31'b0, has_dep1}, 32'h1);
    chk("t2.dep1", {28'b0, dep1}, 32'h2);
    chk("t2.sid1", {28'b0, search_rob_id_1}, 32'h2);
    step("t2a");
    idle(); dec_rs1 = 5'd5; search_ready_1 = 1'b1; search_val_1 = 32'h1234;
    #1;
    chk("t2.val1", val1, 32'h1234);
    step("t2b");

    // Commit bypass then committed value
    idle(); dec_rs2 = 5'd5;
    commit_valid = 1'b1; commit_rob_id = 4'd2; commit_reg_id = 5'd5; commit_val = 32'hABCD;
    #1;
    chk("t3.val2", val2, 32'hABCD);
    chk("t3.hd2", {31'b0, has_dep2}, 32'h0);
    step("t3a");
    idle(); dec_rs2 = 5'd5;
    #1;
    chk("t3.reg5", val2, 32'hABCD);
    step("t3b");

    // Stale-tag commit keeps x7 busy on the newer tag
    issue(5'd7, 4'd1);
    issue(5'd7, 4'd4);
    idle(); commit_valid = 1'b1; commit_rob_id = 4'd1; commit_reg_id = 5'd7; commit_val = 32'h77;
    step("t4a");
    idle(); dec_rs2 = 5'd7;
    #1;
    chk("t4.hd2", {31'b0, has_dep2}, 32'h1);
    chk("t4.dep2", {28'b0, dep2}, 32'h4);
    step("t4b");

    // Same-cycle commit and re-issue of x9
    issue(5'd9, 4'd3);
    idle(); dec_ready = 1'b1; dec_rd = 5'd9; dec_rob_id = 4'd6;
    commit_valid = 1'b1; commit_rob_id = 4'd3; commit_reg_id = 5'd9; commit_val = 32'h99;
    step("t5a");
    idle(); dec_rs1 = 5'd9;
    #1;
    chk("t5.hd1", {31'b0, has_dep1}, 32'h1);
    chk("t5.dep1", {28'b0, dep1}, 32'h6);
    step("t5b");

    // Flush with a concurrent issue to x8
    for (int r = 1; r <= 4; r++) issue(r[4:0], 4'(r + 8));
    idle(); clear = 1'b1; dec_ready = 1'b1; dec_rd = 5'd8; dec_rob_id = 4'd12;
    step("t6a");
    for (int r = 1; r <= 4; r++) begin
      idle(); dec_rs1 = r[4:0]; dec_rs2 = 5'd8;
      #1;
      chk("t6.hd1", {31'b0, has_dep1}, 32'h0);
      chk("t6.hd2", {31'b0, has_dep2}, 32'h0);
      step("t6b");
    end
    idle(); dec_rs1 = 5'd9;
    #1;
    chk("t6.reg9", val1, 32'h99);
    step("t6c");

    // rdy_in low freezes state
    idle(); rdy_in = 1'b0; dec_ready = 1'b1; dec_rd = 5'd11; dec_rob_id = 4'd5;
    commit_valid = 1'b1; commit_rob_id = 4'd0; commit_reg_id = 5'd10; commit_val = 32'hDEAD;
    step("t7a");
    idle(); dec_rs1 = 5'd10; dec_rs2 = 5'd11;
    #1;
    chk("t7.reg10", val1, 32'h0);
    chk("t7.hd2", {31'b0, has_dep2}, 32'h0);
    step("t7b");

    // Async reset mid-operation overrides commit and issue
    idle(); dec_ready = 1'b1; dec_rd = 5'd12; dec_rob_id = 4'd7;
    commit_valid = 1'b1; commit_rob_id = 4'd1; commit_reg_id = 5'd9; commit_val = 32'h5555;
    #2;
    rst_in = 1'b1;
    model_reset();
    #1;
    idle(); dec_rs1 = 5'd9; dec_rs2 = 5'd7;
    dec_ready = 1'b1; dec_rd = 5'd12; commit_valid = 1'b1; commit_reg_id = 5'd9; commit_val = 32'h5555;
    #1;
    chk("t8.val1", val1, 32'h0);
    chk("t8.hd2", {31'b0, has_dep2}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    idle(); dec_rs1 = 5'd9; dec_rs2 = 5'd12;
    step("t8b");

    // Randomized traffic over a small register window
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle();
      rdy_in     = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 19) == 0);
      dec_ready  = $urandom_range(0, 1) == 1;
      dec_rs1    = 5'($urandom_range(0, 9));
      dec_rs2    = 5'($urandom_range(0, 9));
      dec_rd     = 5'($urandom_range(0, 9));
      dec_rob_id = RW'($urandom);
      search_ready_1 = ($urandom_range(0, 3) == 0);
      search_ready_2 = ($urandom_range(0, 3) == 0);
      search_val_1   = $urandom;
      search_val_2   = $urandom;
      commit_valid   = ($urandom_range(0, 9) < 4);
      r = $urandom_range(0, 9);
      commit_reg_id  = 5'(r);
      commit_rob_id  = ($urandom_range(0, 9) < 7) ? m_dep[r] : RW'($urandom);
      commit_val     = $urandom;
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file with rename tags, between the decoder and the reorder buffer. At issue it resolves both source operands to a value or a ROB tag, querying the ROB for results that are written back but not yet committed. It records the issuing instruction's destination tag. It takes ROB commits into the 32×32 register array and drops all rename state on a misprediction flush.

## Interface
- ROB_WIDTH, default 4: ROB index width; ROB_SIZE = 2^ROB_WIDTH.
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  ready; when low, all state holds.
- clear  in  1  misprediction flush from the ROB.
- dec_ready  in  1  decoder issues an instruction this cycle.
- dec_rs1, dec_rs2  in  5  source register indices.
- dec_rd  in  5  destination register index; 0 means no destination.
- dec_rob_id  in  ROB_WIDTH  ROB entry allocated to the issuing instruction.
- val1, val2  out  32  resolved operand values.
- has_dep1, has_dep2  out  1  operand still pending.
- dep1, dep2  out  ROB_WIDTH  ROB tag to wait on; only meaningful when has_dep is 1.
- search_rob_id_1, search_rob_id_2  out  ROB_WIDTH  tag queried in the ROB.
- search_ready_1, search_ready_2  in  1  queried entry has its result.
- search_val_1, search_val_2  in  32  queried entry's result.
- commit_valid  in  1  commit present this cycle.
- commit_rob_id  in  ROB_WIDTH  committing ROB entry.
- commit_reg_id  in  5  committing destination register.
- commit_val  in  32  committed value.

## Operation
- State, per register r in 0..31:
  - regs[r], 32 bits.
  - busy[r], 1 bit.
  - dep[r], ROB_WIDTH bits.
- Operand resolve (per port k, source s), combinational, first match wins:
  - s == 0: val 0, has_dep 0.
  - !busy[s]: val regs[s], has_dep 0.
  - commit_valid && commit_rob_id == dep[s]: val commit_val, has_dep 0 (commit bypass).
  - search_ready_k: val search_val_k, has_dep 0.
  - Otherwise: has_dep 1, dep dep[s], val 0.
- search_rob_id_k = dep[dec_rsk], always driven, independent of dec_ready.
- Operands reflect state before this cycle's issue. An instruction never depends on its own rd, e.g. add x5,x5,x1 reads the old x5 tag.
- Commit, when rdy_in && commit_valid && commit_reg_id != 0:
  - regs[commit_reg_id] <= commit_val.
  - If busy[commit_reg_id] && dep[commit_reg_id] == commit_rob_id, busy <= 0.
  - A stale tag (register renamed again later) keeps busy set.
- Issue, when rdy_in && dec_ready && !clear && dec_rd != 0: busy[dec_rd] <= 1, dep[dec_rd] <= dec_rob_id.
- Same register, same cycle commit-clear and issue: issue wins, busy stays 1 with the new tag, value is still written.
- Flush, when rdy_in && clear:
  - All busy <= 0; dep unchanged.
  - The same-cycle commit value write still happens.
  - Issue is ignored.
- x0: never written, never busy.
- rdy_in low: no state change; combinational outputs still track inputs.

## Timing
- Operand lookup: zero-cycle, combinational from dec_rs*, search_*, commit_*.
- Rename and commit: visible through the array one cycle after the edge. Same-cycle visibility of a commit is only via the bypass.
- Reset (async, immediate):
  - regs = 0, busy = 0, dep = 0.
  - Hence val* = 0, has_dep* = 0, dep* = 0, search_rob_id_* = 0.
- First cycle after clear: every operand resolves from regs with has_dep 0.
- Reset asserted mid-operation overrides a concurrent commit or issue; neither is applied.

## Structure
- Shared defines file holds ROB_WIDTH, ROB_SIZE, and REG_NUM = 32, the same definitions the ROB and RS use.
- One natural sub-module, regfile_read_port: a combinational resolve instantiated once per source port, with inputs busy, dep, regs value, commit bypass and search results.
- Register and tag arrays stay in the top level.

## Test plan
- Reset, then issue rs1=3, rs2=0 → val1=0, has_dep1=0, val2=0, has_dep2=0.
- Issue rd=5, rob_id=2. Next cycle read rs1=5 with search_ready_1=0 → has_dep1=1, dep1=2, search_rob_id_1=2. Then search_ready_1=1, search_val_1=0x1234 → val1=0x1234, has_dep1=0.
- x5 tagged 2, commit_valid with rob_id=2, reg=5, val=0xABCD while reading rs2=5 → val2=0xABCD, has_dep2=0 that cycle. Next cycle busy[5]=0, regs[5]=0xABCD.
- Tag x7 with 1, then re-tag with 4, then commit rob 1 for x7 → regs[7] updated, busy[7] stays 1, dep2=4 when read.
- Same cycle: commit rob 3 → x9 and issue rd=9, rob_id=6 → busy[9]=1, dep=6, regs[9]=commit_val.
- x1..x4 busy, pulse clear with dec_ready=1, rd=8 → all has_dep=0 next cycle, x8 not busy. Then hold rdy_in low with commits → no state change.
